ps2_cmd_sequencer: RTL

- Sits between the CPU MMIO path and the PS/2 controller's byte-wide MMIO port, and shares that port between the two.
- Issues keyboard/mouse command sequences autonomously: a command byte plus an optional argument byte. Each byte waits for 0xFA ACK, is re-sent on 0xFE, and times out if the device is silent.
- Frees firmware from polling loops for LED updates, resets and typematic configuration.
- When idle, the CPU has transparent access to the PS/2 controller.

---
 rtl/ps2_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 command sequencer: shares the controller MMIO port with the CPU
// and runs command/argument byte exchanges with ACK, resend and timeout.
module ps2_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1660000,
  parameter int MAX_RETRY      = 3,
  parameter int READ_LAT       = 2
) (
  input  logic       main_clk,
  input  logic       main_reset_n,
  input  logic [2:0] cpu_address,
  input  logic [7:0] cpu_data_write,
  input  logic       cpu_is_write,
  output logic [7:0] cpu_data_read,
  output logic       cpu_busy,
  output logic [2:0] ps2_address,
  output logic [7:0] ps2_data_write,
  output logic       ps2_is_write,
  input  logic [7:0] ps2_data_read,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic [1:0] cmd_status,
  output logic [7:0] discard_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(READ_LAT + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PH_RD     = PW'(READ_LAT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TMO = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_POLL_TXQ,
    S_SEND,
    S_POLL_RX,
    S_READ_RX,
    S_POP,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          arg_ph_q, arg_ph_d;
  logic [7:0]    rx_q, rx_d;
  logic [1:0]    status_q, status_d;
  logic [7:0]    discard_q, discard_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          has_arg_q, has_arg_d;
  logic [7:0]    arg_q, arg_d;

  logic [2:0]    seq_addr;
  logic [7:0]    seq_wdata;
  logic          seq_wr;
  logic          rd_done;
  logic          tmo_hit;
  logic [7:0]    cur_byte;

  assign rd_done  = (ph_q == PH_RD);
  assign tmo_hit  = (tmo_q >= TMO_LAST);
  assign cur_byte = arg_ph_q ? arg_q : cmd_q;

  always_ff @(posedge main_clk or negedge main_reset_n) begin
    if (!main_reset_n) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      arg_ph_q  <= 1'b0;
      rx_q      <= 8'h00;
      status_q  <= ST_OK;
      discard_q <= 8'h00;
      cmd_q     <= 8'h00;
      has_arg_q <= 1'b0;
      arg_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      arg_ph_q  <= arg_ph_d;
      rx_q      <= rx_d;
      status_q  <= status_d;
      discard_q <= discard_d;
      cmd_q     <= cmd_d;
      has_arg_q <= has_arg_d;
      arg_q     <= arg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    tmo_d     = tmo_hit ? tmo_q : tmo_q + TW'(1);
    retry_d   = retry_q;
    arg_ph_d  = arg_ph_q;
    rx_d      = rx_q;
    status_d  = status_q;
    discard_d = discard_q;
    cmd_d     = cmd_q;
    has_arg_d = has_arg_q;
    arg_d     = arg_q;
    seq_addr  = 3'd0;
    seq_wdata = 8'h00;
    seq_wr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (cmd_valid) begin
          cmd_d     = cmd_byte;
          has_arg_d = cmd_has_arg;
          arg_d     = cmd_arg;
          arg_ph_d  = 1'b0;
          retry_d   = '0;
          state_d   = S_START;
        end
      end
      // Idle gap so a CPU read issued in the accept cycle drains first
      S_START: begin
        ph_d    = '0;
        tmo_d   = '0;
        state_d = S_POLL_TXQ;
      end
      S_POLL_TXQ: begin
        seq_addr = 3'd3;
        if (rd_done && ps2_data_read == 8'h00) begin
          ph_d    = '0;
          tmo_d   = '0;
          state_d = S_SEND;
        end else if (tmo_hit) begin
          status_d = ST_TMO;
          state_d  = S_DONE;
        end else begin
          ph_d = rd_done ? '0 : ph_q + PW'(1);
        end
      end
      S_SEND: begin
        seq_addr  = 3'd1;
        seq_wdata = cur_byte;
        seq_wr    = (ph_q == '0);
        if (ph_q == '0) begin
          ph_d = PW'(1);
        end else begin
          ph_d    = '0;
          state_d = S_POLL_RX;
        end
      end
      S_POLL_RX: begin
        seq_addr = 3'd2;
        if (rd_done && ps2_data_read[0]) begin
          ph_d    = '0;
          state_d = S_READ_RX;
        end else if (tmo_hit) begin
          status_d = ST_TMO;
          state_d  = S_DONE;
        end else begin
          ph_d = rd_done ? '0 : ph_q + PW'(1);
        end
      end
      S_READ_RX: begin
        seq_addr = 3'd0;
        if (rd_done) begin
          rx_d    = ps2_data_read;
          ph_d    = '0;
          state_d = S_POP;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_POP: begin
        seq_addr = 3'd0;
        seq_wr   = (ph_q == '0);
        if (ph_q == '0) begin
          ph_d = PW'(1);
        end else begin
          ph_d    = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        ph_d = '0;
        unique case (1'b1)
          (rx_q == 8'hFA): begin
            if (!arg_ph_q && has_arg_q) begin
              arg_ph_d = 1'b1;
              retry_d  = '0;
              tmo_d    = '0;
              state_d  = S_POLL_TXQ;
            end else begin
              status_d = ST_OK;
              state_d  = S_DONE;
            end
          end
          (rx_q == 8'hFE): begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RW'(1);
              tmo_d   = '0;
              state_d = S_POLL_TXQ;
            end else begin
              status_d = ST_RTY;
              state_d  = S_DONE;
            end
          end
          (rx_q == 8'hFC || rx_q == 8'h00): begin
            status_d = ST_ERR;
            state_d  = S_DONE;
          end
          default: begin
            // Unsolicited byte: keep waiting on the same timeout window
            if (discard_q != 8'hFF) discard_d = discard_q + 8'd1;
            state_d = S_POLL_RX;
          end
        endcase
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cpu_busy      = (state_q != S_IDLE);
  assign cmd_ready     = (state_q == S_IDLE);
  assign cmd_done      = (state_q == S_DONE);
  assign cmd_status    = status_q;
  assign discard_count = discard_q;

  assign ps2_address    = cpu_busy ? seq_addr : cpu_address;
  assign ps2_data_write = cpu_busy ? seq_wdata : cpu_data_write;
  assign ps2_is_write   = cpu_busy ? seq_wr : cpu_is_write;
  assign cpu_data_read  = cpu_busy ? 8'hFF : ps2_data_read;

endmodule
